// File: rtl/tm_sr_emulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tm_sr_emulator_pkg
// Description : Shared constants and FSM encoding for the TMIIa shift-register
//               chip-side emulator.
// Revision    : 1.0 - initial release
// ============================================================================
package tm_sr_emulator_pkg;

    // Defaults match the shift-register controller on the other end of the link.
    localparam int c_tm_width     = 170;
    localparam int c_tm_cnt_width = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle     = 2'd0;
    localparam state_t c_st_shifting = 2'd1;
    localparam state_t c_st_load     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/tm_sr_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : tm_sr_emulator_if
// Description : Serial link plus host-side preload/readback bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface tm_sr_emulator_if #(
    parameter int WIDTH     = tm_sr_emulator_pkg::c_tm_width,
    parameter int CNT_WIDTH = tm_sr_emulator_pkg::c_tm_cnt_width
) ();
    logic                 sr_clk;
    logic                 sr_din;
    logic                 sr_load;
    logic                 sr_dout;
    logic                 preload_en;
    logic [WIDTH-1:0]     preload_data;
    logic [WIDTH-1:0]     cfg_out;
    logic                 cfg_valid;
    logic                 frame_err;
    logic [CNT_WIDTH-1:0] shift_count;
    logic                 busy;

    modport master (
        output sr_clk, sr_din, sr_load, preload_en, preload_data,
        input  sr_dout, cfg_out, cfg_valid, frame_err, shift_count, busy
    );

    modport slave (
        input  sr_clk, sr_din, sr_load, preload_en, preload_data,
        output sr_dout, cfg_out, cfg_valid, frame_err, shift_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/tm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : tm_sync_edge
// Description : Two-flop synchronizer followed by a history flop; emits a
//               one-cycle pulse on each rising edge of the async input.
// Revision    : 1.0 - initial release
// ============================================================================
module tm_sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_hist;
endmodule
`default_nettype wire

// File: rtl/tm_sr_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tm_sr_emulator
// Description : Chip end of the TMIIa configuration shift-register link, for
//               FPGA loopback testing of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tm_sr_emulator
    import tm_sr_emulator_pkg::*;
#(
    parameter int               WIDTH           = c_tm_width,
    parameter int               CNT_WIDTH       = c_tm_cnt_width,
    parameter int               SHIFT_DIRECTION = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE      = {WIDTH{1'b0}}
) (
    input  wire logic       clk,
    input  wire logic       rst,
    tm_sr_emulator_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_full = CNT_WIDTH'(WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic                 w_clk_rise;
    logic                 w_load_rise;
    logic                 r_din_meta;
    logic                 r_din_sync;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_busy;
    logic                 w_load_act;
    logic                 w_preload_ok;

    logic [WIDTH-1:0]     r_sr;
    logic [WIDTH-1:0]     w_sr_shift;
    logic                 w_shift_out;
    logic                 w_preload_out;
    logic                 c_init_out;
    logic                 r_dout;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     r_cfg;
    logic                 r_valid;
    logic                 r_err;

    tm_sync_edge u_clk_edge (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.sr_clk),
        .o_rise  (w_clk_rise)
    );

    tm_sync_edge u_load_edge (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.sr_load),
        .o_rise  (w_load_rise)
    );

    // Data needs no edge history; its second stage lines up with the clock pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_meta <= 1'b0;
            r_din_sync <= 1'b0;
        end else begin
            r_din_meta <= bus.sr_din;
            r_din_sync <= r_din_meta;
        end
    end

    generate
        if (SHIFT_DIRECTION != 0) begin : g_msb_out
            assign w_sr_shift    = {r_sr[WIDTH-2:0], r_din_sync};
            assign w_shift_out   = w_sr_shift[WIDTH-1];
            assign w_preload_out = bus.preload_data[WIDTH-1];
            assign c_init_out    = INIT_VALUE[WIDTH-1];
        end else begin : g_lsb_out
            assign w_sr_shift    = {r_din_sync, r_sr[WIDTH-1:1]};
            assign w_shift_out   = w_sr_shift[0];
            assign w_preload_out = bus.preload_data[0];
            assign c_init_out    = INIT_VALUE[0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_next;
    end

    // A load edge coinciding with a clock edge still takes the shift this cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_load_rise)     w_state_next = c_st_load;
                else if (w_clk_rise) w_state_next = c_st_shifting;
            end
            c_st_shifting: begin
                if (w_load_rise)     w_state_next = c_st_load;
            end
            c_st_load: begin
                w_state_next = w_clk_rise ? c_st_shifting : c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_busy       = (r_state == c_st_shifting);
        w_load_act   = (r_state == c_st_load);
        w_preload_ok = (r_state == c_st_idle) && !w_clk_rise && bus.preload_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr    <= INIT_VALUE;
            r_dout  <= c_init_out;
            r_cnt   <= '0;
            r_cfg   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_load_act;
            if (w_clk_rise) begin
                r_sr   <= w_sr_shift;
                r_dout <= w_shift_out;
            end else if (w_preload_ok) begin
                r_sr   <= bus.preload_data;
                r_dout <= w_preload_out;
            end
            if (w_load_act) begin
                r_cfg <= r_sr;
                r_err <= (r_cnt != c_cnt_full);
                r_cnt <= w_clk_rise ? c_cnt_one : '0;
            end else if (w_clk_rise && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign bus.sr_dout     = r_dout;
    assign bus.cfg_out     = r_cfg;
    assign bus.cfg_valid   = r_valid;
    assign bus.frame_err   = r_err;
    assign bus.shift_count = r_cnt;
    assign bus.busy        = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_tm_sr_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tm_sr_emulator
// Description : Directed bench for tm_sr_emulator (both shift directions)
//               against an event-level model of the link.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tm_sr_emulator;
    localparam int W = 170;
    localparam logic [W-1:0] c_pat  = {2'b01, {21{8'hA5}}};
    localparam logic [W-1:0] c_pre  = 170'h3_DEADBEEF_0123456789ABCDEF_FEDCBA9876543210_FF;
    localparam logic [W-1:0] c_ones = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sr_clk = 1'b0;
    logic         sr_din = 1'b0;
    logic         sr_load = 1'b0;
    logic         preload_en = 1'b0;
    logic [W-1:0] preload_data = '0;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int e_cnt = 0;
    bit ev_clk [8];
    bit ev_load[8];
    bit ev_din [8];

    always #5 clk = ~clk;

    tm_sr_emulator_if #(.WIDTH(W), .CNT_WIDTH(8)) bus0 ();
    tm_sr_emulator_if #(.WIDTH(W), .CNT_WIDTH(8)) bus1 ();

    assign bus0.sr_clk = sr_clk;   assign bus1.sr_clk = sr_clk;
    assign bus0.sr_din = sr_din;   assign bus1.sr_din = sr_din;
    assign bus0.sr_load = sr_load; assign bus1.sr_load = sr_load;
    assign bus0.preload_en = preload_en;     assign bus1.preload_en = preload_en;
    assign bus0.preload_data = preload_data; assign bus1.preload_data = preload_data;

    tm_sr_emulator #(.WIDTH(W), .CNT_WIDTH(8), .SHIFT_DIRECTION(0), .INIT_VALUE(170'h1)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );
    tm_sr_emulator #(.WIDTH(W), .CNT_WIDTH(8), .SHIFT_DIRECTION(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );

    logic [W-1:0] a_cfg  [2];
    logic         a_dout [2];
    logic         a_valid[2];
    logic         a_err  [2];
    logic         a_busy [2];
    logic [7:0]   a_cnt  [2];
    assign a_cfg[0] = bus0.cfg_out;     assign a_cfg[1] = bus1.cfg_out;
    assign a_dout[0] = bus0.sr_dout;    assign a_dout[1] = bus1.sr_dout;
    assign a_valid[0] = bus0.cfg_valid; assign a_valid[1] = bus1.cfg_valid;
    assign a_err[0] = bus0.frame_err;   assign a_err[1] = bus1.frame_err;
    assign a_busy[0] = bus0.busy;       assign a_busy[1] = bus1.busy;
    assign a_cnt[0] = bus0.shift_count; assign a_cnt[1] = bus1.shift_count;

    // Model: per instance (0: LSB leaves first, 1: MSB leaves first).
    // m_st: 0 idle, 1 shifting, 2 load cycle.
    logic [W-1:0] m_sr [2];
    logic [W-1:0] m_cfg[2];
    logic         m_valid[2];
    logic         m_err[2];
    int           m_cnt[2];
    int           m_st [2];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pin edges driven at a negedge take effect at the third following posedge.
    always @(posedge clk or posedge rst) begin : model
        logic [W-1:0] sr;
        int  cnt, st, nst, idx;
        bit  ce, le, d;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cfg[i] = '0; m_valid[i] = 1'b0; m_err[i] = 1'b0;
                m_cnt[i] = 0;  m_st[i] = 0;
            end
            m_sr[0] = 170'h1;
            m_sr[1] = '0;
            for (int k = 0; k < 8; k++) begin
                ev_clk[k] = 1'b0; ev_load[k] = 1'b0; ev_din[k] = 1'b0;
            end
        end else begin
            e_cnt++;
            idx = e_cnt % 8;
            ce = ev_clk[idx]; le = ev_load[idx]; d = ev_din[idx];
            ev_clk[idx] = 1'b0; ev_load[idx] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                sr = m_sr[i]; cnt = m_cnt[i]; st = m_st[i];
                m_valid[i] = 1'b0;
                if (st == 2) begin
                    m_cfg[i] = sr; m_valid[i] = 1'b1; m_err[i] = (cnt != W); cnt = 0;
                end
                if (ce) begin
                    sr = (i == 1) ? {sr[W-2:0], d} : {d, sr[W-1:1]};
                    if (cnt < 255) cnt++;
                end else if (preload_en && st == 0) begin
                    sr = preload_data;
                end
                if (st == 2)  nst = ce ? 1 : 0;
                else if (le)  nst = 2;
                else if (ce)  nst = 1;
                else          nst = st;
                m_sr[i] = sr; m_cnt[i] = cnt; m_st[i] = nst;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.sr_dout", i), W'(a_dout[i]), W'((i == 1) ? m_sr[1][W-1] : m_sr[0][0]));
                chk($sformatf("u%0d.cfg_out", i), a_cfg[i], m_cfg[i]);
                chk($sformatf("u%0d.cfg_valid", i), W'(a_valid[i]), W'(m_valid[i]));
                chk($sformatf("u%0d.frame_err", i), W'(a_err[i]), W'(m_err[i]));
                chk($sformatf("u%0d.shift_count", i), W'(a_cnt[i]), W'(m_cnt[i]));
                chk($sformatf("u%0d.busy", i), W'(a_busy[i]), W'(m_st[i] == 1));
            end
            if (a_valid[1]) valid_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rise_bit(input logic d, input logic with_load);
        sr_din = d;
        sr_clk = 1'b0;
        tick(4);
        sr_clk  = 1'b1;
        sr_load = with_load;
        ev_clk[(e_cnt + 3) % 8] = 1'b1;
        ev_din[(e_cnt + 3) % 8] = d;
        if (with_load) ev_load[(e_cnt + 3) % 8] = 1'b1;
    endtask

    task automatic shift_bit(input logic d);
        rise_bit(d, 1'b0);
        tick(4);
    endtask

    task automatic load_pulse();
        sr_load = 1'b1;
        ev_load[(e_cnt + 3) % 8] = 1'b1;
        tick(4);
        sr_load = 1'b0;
        tick(4);
    endtask

    task automatic preload(input logic [W-1:0] v);
        preload_data = v;
        preload_en   = 1'b1;
        tick(1);
        preload_en   = 1'b0;
    endtask

    initial begin
        logic exp_old, exp_new;
        tick(3);
        chk("rst u0.sr_dout", W'(bus0.sr_dout), W'(1));
        chk("rst u1.sr_dout", W'(bus1.sr_dout), W'(0));
        chk("rst u0.cfg_out", bus0.cfg_out, '0);
        chk("rst u1.cfg_out", bus1.cfg_out, '0);
        chk("rst u1.cfg_valid", W'(bus1.cfg_valid), W'(0));
        chk("rst u1.shift_count", W'(bus1.shift_count), W'(0));
        rst = 1'b0;
        tick(2);

        // Full pattern frame, MSB first.
        shift_bit(c_pat[W-1]);
        chk("A busy", W'(bus1.busy), W'(1));
        for (int i = W - 2; i >= 0; i--) shift_bit(c_pat[i]);
        chk("A count", W'(bus1.shift_count), W'(170));
        valid_cnt = 0;
        load_pulse();
        chk("A cfg_out", bus1.cfg_out, c_pat);
        chk("A valid width", W'(valid_cnt), W'(1));
        chk("A frame_err", W'(bus1.frame_err), W'(0));
        chk("A count clear", W'(bus1.shift_count), W'(0));

        // Preload then read it back through zeros, checking the 3-cycle step.
        preload(c_pre);
        chk("B first out", W'(bus1.sr_dout), W'(1));
        for (int i = 0; i < W; i++) begin
            exp_old = c_pre[W-1-i];
            if (i < W - 1) exp_new = c_pre[W-2-i];
            else           exp_new = 1'b0;
            rise_bit(1'b0, 1'b0);
            tick(2);
            chk("B hold", W'(bus1.sr_dout), W'(exp_old));
            tick(1);
            chk("B step", W'(bus1.sr_dout), W'(exp_new));
            tick(1);
        end
        load_pulse();
        chk("B frame_err", W'(bus1.frame_err), W'(0));

        // Short frame, with a preload attempt that must be ignored.
        for (int i = W - 1; i >= 1; i--) begin
            shift_bit(c_pat[i]);
            if (i == W - 10) begin
                preload(c_ones);
                chk("C count", W'(bus1.shift_count), W'(10));
            end
        end
        load_pulse();
        chk("C frame_err short", W'(bus1.frame_err), W'(1));
        chk("C cfg_out short", bus1.cfg_out, c_pat >> 1);
        for (int i = W - 1; i >= 0; i--) shift_bit(c_pre[i]);
        load_pulse();
        chk("C frame_err full", W'(bus1.frame_err), W'(0));
        chk("C cfg_out full", bus1.cfg_out, c_pre);

        // Last bit and load edge arrive together.
        for (int i = W - 1; i >= 1; i--) shift_bit(c_pat[i]);
        valid_cnt = 0;
        rise_bit(c_pat[0], 1'b1);
        tick(3);
        chk("D count", W'(bus1.shift_count), W'(170));
        tick(1);
        sr_load = 1'b0;
        tick(4);
        chk("D cfg_out", bus1.cfg_out, c_pat);
        chk("D frame_err", W'(bus1.frame_err), W'(0));
        chk("D count clear", W'(bus1.shift_count), W'(0));
        chk("D valid width", W'(valid_cnt), W'(1));

        // Reset in the middle of a frame.
        for (int i = 0; i < 80; i++) shift_bit(c_pre[W-1-i]);
        sr_clk = 1'b0;
        tick(4);
        chk("E count before", W'(bus1.shift_count), W'(80));
        valid_cnt = 0;
        rst = 1'b1;
        tick(1);
        chk("E count", W'(bus1.shift_count), W'(0));
        chk("E busy", W'(bus1.busy), W'(0));
        chk("E cfg_out", bus1.cfg_out, '0);
        chk("E u0.sr_dout", W'(bus0.sr_dout), W'(1));
        rst = 1'b0;
        tick(10);
        chk("E no valid", W'(valid_cnt), W'(0));

        // Load with nothing shifted.
        load_pulse();
        chk("F frame_err", W'(bus1.frame_err), W'(1));
        chk("F u0.cfg_out", bus0.cfg_out, 170'h1);
        chk("F valid width", W'(valid_cnt), W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
